// File: rtl/uc_seq.sv
// uc_seq: control unit for the single-cycle microcontroller datapath.
// Decodes the 6-bit opcode into datapath controls. A RUN/HALT state
// machine freezes the machine on HALT. A sticky illegal-opcode flag and a
// saturating retired-instruction counter support debug.
module uc_seq #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             zero,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [2:0]       ALUOp,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic op_reg, op_ldi, op_j, op_jz, op_jnz, op_halt, op_legal;

    // Classify the opcode; everything not matched is an illegal NOP.
    always_comb begin
        op_reg   = ~Opcode[5];
        op_ldi   = (Opcode[5:2] == 4'b1000);
        op_j     = (Opcode == 6'b110000);
        op_jz    = (Opcode == 6'b110001);
        op_jnz   = (Opcode == 6'b110010);
        op_halt  = (Opcode == 6'b111111);
        op_legal = op_reg | op_ldi | op_j | op_jz | op_jnz | op_halt;
    end

    // Datapath controls: reset forces a safe NOP, HALT reloads the PC target.
    always_comb begin
        s_inc = 1'b1;
        s_inm = 1'b0;
        we    = 1'b0;
        wez   = 1'b0;
        ALUOp = 3'b000;
        if (!reset) begin
            if (state_q == StHalt) begin
                s_inc = 1'b0;
            end else if (op_reg) begin
                ALUOp = Opcode[4:2];
                we    = 1'b1;
                wez   = 1'b1;
            end else if (op_ldi) begin
                // ALUOp stays 000: pass operand B (the immediate)
                s_inm = 1'b1;
                we    = 1'b1;
                wez   = 1'b1;
            end else if (op_j) begin
                s_inc = 1'b0;
            end else if (op_jz) begin
                s_inc = ~zero;
            end else if (op_jnz) begin
                s_inc = zero;
            end else if (op_halt) begin
                // jump-to-self; the state register takes over from next cycle
                s_inc = 1'b0;
            end
        end
    end

    // Next-state for the FSM, sticky illegal flag and retired counter.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if (reset) begin
            state_d   = StRun;
            illegal_d = 1'b0;
            cnt_d     = '0;
        end else if (state_q == StRun) begin
            if (op_halt) begin
                state_d = StHalt;
            end
            if (!op_legal) begin
                illegal_d = 1'b1;
            end else if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    // State registers; reset is applied through the next-state logic.
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        illegal_q <= illegal_d;
        cnt_q     <= cnt_d;
    end

    assign halted      = (state_q == StHalt);
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_uc_seq.sv
// Scoreboard bench for uc_seq: the driver pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares.
module tb_uc_seq;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [5:0]    Opcode = 6'd0;
    logic          zero = 1'b0;
    logic          s_inc, s_inm, we, wez, halted, illegal;
    logic [2:0]    ALUOp;
    logic [CW-1:0] instr_count;

    uc_seq #(.CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .Opcode      (Opcode),
        .zero        (zero),
        .s_inc       (s_inc),
        .s_inm       (s_inm),
        .we          (we),
        .wez         (wez),
        .ALUOp       (ALUOp),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s_inc, s_inm, we, wez, alu, halted, illegal, cnt;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // model state
    int   m_halted = 0;
    int   m_ill = 0;
    int   m_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // 0 reg, 1 ldi, 2 J, 3 JZ, 4 JNZ, 5 HALT, 6 illegal
    function automatic int kind(input int op);
        if (op < 32) return 0;
        if (op < 36) return 1;
        if (op == 48) return 2;
        if (op == 49) return 3;
        if (op == 50) return 4;
        if (op == 63) return 5;
        return 6;
    endfunction

    task automatic step(input bit r, input int op, input bit z, input bit push);
        exp_t e;
        int   k;
        @(posedge clk);
        #1;
        reset  = r;
        Opcode = op[5:0];
        zero   = z;
        k = kind(op);
        e.halted = m_halted; e.illegal = m_ill; e.cnt = m_cnt;
        e.s_inc = 1; e.s_inm = 0; e.we = 0; e.wez = 0; e.alu = 0;
        if (!r) begin
            if (m_halted != 0) e.s_inc = 0;
            else if (k == 0) begin e.alu = (op / 4) % 8; e.we = 1; e.wez = 1; end
            else if (k == 1) begin e.s_inm = 1; e.we = 1; e.wez = 1; end
            else if (k == 2 || k == 5) e.s_inc = 0;
            else if (k == 3) e.s_inc = z ? 0 : 1;
            else if (k == 4) e.s_inc = z ? 1 : 0;
        end
        if (push) sb.push_back(e);
        if (r) begin
            m_halted = 0; m_ill = 0; m_cnt = 0;
        end else if (m_halted == 0) begin
            if (k == 6) m_ill = 1;
            else if (m_cnt < CMAX) m_cnt++;
            if (k == 5) m_halted = 1;
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("s_inc", int'(s_inc), e.s_inc);
            chk("s_inm", int'(s_inm), e.s_inm);
            chk("we", int'(we), e.we);
            chk("wez", int'(wez), e.wez);
            chk("ALUOp", int'(ALUOp), e.alu);
            chk("halted", int'(halted), e.halted);
            chk("illegal", int'(illegal), e.illegal);
            chk("instr_count", int'(instr_count), e.cnt);
        end
    end

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        repeat (3) step(0, 6'b000100, 0, 1);
        step(0, 6'b100011, 0, 1);
        step(0, 6'b110001, 1, 1);
        step(0, 6'b110001, 0, 1);
        step(0, 6'b110010, 1, 1);
        step(0, 6'b110010, 0, 1);
        step(0, 6'b101000, 0, 1);
        repeat (5) step(0, 6'b000000, 0, 1);
        step(0, 6'b111111, 0, 1);
        repeat (4) step(0, 6'b000000, 1, 1);
        step(1, 6'b000000, 0, 1);
        step(0, 6'b000000, 0, 1);
        step(1, 6'b111111, 0, 1);
        step(0, 6'b000000, 0, 1);
        repeat (20) step(0, 6'b010100, 0, 1);
        step(1, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            int op;
            bit r;
            op = $urandom_range(0, 63);
            if ($urandom_range(0, 31) == 0) op = 63;
            if ($urandom_range(0, 7) == 0) op = $urandom_range(48, 50);
            r = ($urandom_range(0, 15) == 0);
            step(r, op, 1'($urandom_range(0, 1)), 1);
        end
        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uc_seq.md
Name: uc_seq

Overview:
- Control unit for the single-cycle, data-memory-less microcontroller datapath.
- Consumes the datapath's 6-bit Opcode (instruction bits [15:10]) and the registered zero flag.
- Drives s_inc, s_inm, we, wez and ALUOp back into the datapath.
- Adds sequential supervision on top of the combinational decode: a RUN/HALT state machine, a sticky illegal-opcode flag and a saturating retired-instruction counter for debug and verification.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Opcode  input  6  instruction bits [15:10] from the datapath
- zero  input  1  registered zero flag from the datapath
- s_inc  output  1  PC mux select: 1 = PC+1, 0 = jump target (instr[9:0])
- s_inm  output  1  1 = immediate operand path (instr[11:4]) and write address instr[3:0]
- we  output  1  register-file write enable
- wez  output  1  zero-flag register write enable
- ALUOp  output  3  ALU operation select
- halted  output  1  1 while in HALT state
- illegal  output  1  sticky: an illegal opcode was seen since reset
- instr_count  output  CNT_W  retired legal instructions since reset

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Control outputs are combinational from Opcode, zero, state and reset. halted, illegal and instr_count are registered.
- Decode in RUN with reset=0:
  - Opcode[5]=0, register ALU op: ALUOp=Opcode[4:2], s_inm=0, we=1, wez=1, s_inc=1. Opcode[1:0] are register-address bits and are ignored.
  - Opcode[5:2]=1000, load immediate: ALUOp=000 (pass operand B), s_inm=1, we=1, wez=1, s_inc=1. Opcode[1:0] are immediate bits and are ignored.
  - 110000, J: s_inc=0, we=0, wez=0.
  - 110001, JZ: s_inc=~zero, we=0, wez=0.
  - 110010, JNZ: s_inc=zero, we=0, wez=0.
  - 111111, HALT: jump-to-self encoding (the assembler places the instruction's own address in [9:0]). s_inc=0, we=0, wez=0.
  - All other Opcode[5]=1 codes (1001xx, 1010xx, 1011xx, 110011 through 111110) are illegal and execute as NOP: s_inc=1, we=0, wez=0.
- Don't-care outputs: ALUOp=000 and s_inm=0 whenever they are not used.
- State machine (RUN, HALT):
  - RUN to HALT on a clock edge where state=RUN and Opcode=111111.
  - HALT is left only by reset.
  - In HALT: s_inc=0, we=0, wez=0, s_inm=0, ALUOp=000, regardless of Opcode or zero. The PC reloads the halt target, so the machine freezes.
- illegal flag: set at the edge ending a RUN cycle with an illegal opcode; stays 1 until reset. Not set while in HALT.
- instr_count: increments by 1 at each edge ending a RUN cycle with a legal opcode, including the HALT issue cycle. Saturates at 2^CNT_W-1 with no wrap. Illegal cycles and HALT-state cycles do not count.
- Reset:
  - While reset=1: we=0, wez=0, s_inc=1, s_inm=0, ALUOp=000.
  - At the edge with reset=1: state=RUN, halted=0, illegal=0, instr_count=0.
  - Reset takes priority over everything, including a simultaneous HALT decode and reset asserted while halted.
- zero is sampled combinationally. A JZ immediately after a flag-writing instruction sees the flag written at the preceding edge.

Test Plan:
- Reset then Opcode=000100 (ALUOp 001) for 3 cycles -> we=1, wez=1, s_inc=1, ALUOp=001; instr_count=3; halted=0, illegal=0.
- Opcode=100011 -> s_inm=1, ALUOp=000, we=1. Then JZ (110001) with zero=1 -> s_inc=0; with zero=0 -> s_inc=1. JNZ gives the opposite result in both cases.
- Opcode=101000 (illegal) for 1 cycle -> we=0, wez=0, s_inc=1; illegal=1 afterwards and stays 1 after 5 further legal opcodes; instr_count excludes the illegal cycle.
- Opcode=111111 -> s_inc=0 that cycle; halted=1 next edge. Then Opcode=000000 for 4 cycles -> we stays 0, s_inc stays 0, instr_count frozen.
- While halted, assert reset 1 cycle -> halted=0, illegal=0, instr_count=0 after the edge; reset coinciding with Opcode=111111 -> stays RUN.
- CNT_W=4: 20 legal instructions -> instr_count saturates at 15.
